branch_hazard_ctrl: RTL

- Sequences the ID-stage branch/jump-register comparator.
- Selects the forwarding source for the comparator's rs and rt operands (ALUSrcC / ALUSrcD).
- Stalls the front end (PCWrite, IF/ID hold, ID/EX bubble) when a branch operand is not yet forwardable:
  - a load is in EX, or
  - memory data in MEM is not ready.
- Sits beside the comparator in ID and drives its PCWrite gate, so no branch resolves or flushes during a stall.

---
 rtl/branch_hazard_ctrl_pkg.sv | 25 ++
 rtl/branch_hazard_ctrl_fwd_sel.sv | 35 +++
 rtl/branch_hazard_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch hazard controller.
package branch_hazard_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    MEM_WAIT  = 2'd2
  } state_e;

  // Comparator operand source selects.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // MEM_WAIT run-length counter width; saturates at all-ones (255).
  localparam int unsigned WAIT_W = 8;

  // Saturating increment for the MEM_WAIT counter.
  function automatic logic [WAIT_W-1:0] wait_inc(input logic [WAIT_W-1:0] v);
    return (v == '1) ? v : v + WAIT_W'(1);
  endfunction

endpackage

// File: rtl/branch_hazard_ctrl_fwd_sel.sv
// Priority forwarding selector for one comparator operand (EX > MEM > WB > regfile).
module branch_hazard_ctrl_fwd_sel
  import branch_hazard_ctrl_pkg::*;
(
  input  logic       use_src,
  input  logic [4:0] src,
  input  logic       ex_rw,
  input  logic [4:0] ex_wreg,
  input  logic       mem_rw,
  input  logic [4:0] mem_wreg,
  input  logic       wb_rw,
  input  logic [4:0] wb_wreg,
  output logic [1:0] sel_c,
  output logic       ex_hit_c,
  output logic       mem_hit_c
);

  logic live;
  logic wb_hit;

  // Register 0 and unused operands never match any stage.
  assign live      = use_src && (src != 5'd0);
  assign ex_hit_c  = live && ex_rw  && (ex_wreg  == src);
  assign mem_hit_c = live && mem_rw && (mem_wreg == src);
  assign wb_hit    = live && wb_rw  && (wb_wreg  == src);

  // Youngest producing stage wins.
  always_comb begin
    sel_c = FWD_REG;
    if (ex_hit_c)       sel_c = FWD_EX;
    else if (mem_hit_c) sel_c = FWD_MEM;
    else if (wb_hit)    sel_c = FWD_WB;
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch/jr comparator sequencer: operand forwarding selects, front-end
// stall on load-use or slow memory, MEM_WAIT timeout flag.
// Optional BRANCH_HAZARD_PERF_EN adds a saturating stall-cycle counter (stall_cnt).
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_MEM_WAIT = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_useRs,
  input  logic             ID_useRt,
  input  logic             EX_regWrite,
  input  logic             EX_memRead,
  input  logic [4:0]       EX_wreg,
  input  logic             MEM_regWrite,
  input  logic             MEM_memRead,
  input  logic [4:0]       MEM_wreg,
  input  logic             mem_ready,
  input  logic             WB_regWrite,
  input  logic [4:0]       WB_wreg,
  output logic [1:0]       ALUSrcC,
  output logic [1:0]       ALUSrcD,
  output logic             PCWrite,
  output logic             IFID_write,
  output logic             IDEX_bubble,
`ifdef BRANCH_HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             timeout_err
);

  logic rs_ex_hit, rs_mem_hit, rt_ex_hit, rt_mem_hit;
  logic haz_ex, haz_mem, stall;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  branch_hazard_ctrl_fwd_sel u_fwd_rs (
    .use_src   (ID_useRs),
    .src       (ID_rs),
    .ex_rw     (EX_regWrite),
    .ex_wreg   (EX_wreg),
    .mem_rw    (MEM_regWrite),
    .mem_wreg  (MEM_wreg),
    .wb_rw     (WB_regWrite),
    .wb_wreg   (WB_wreg),
    .sel_c     (ALUSrcC),
    .ex_hit_c  (rs_ex_hit),
    .mem_hit_c (rs_mem_hit)
  );

  branch_hazard_ctrl_fwd_sel u_fwd_rt (
    .use_src   (ID_useRt),
    .src       (ID_rt),
    .ex_rw     (EX_regWrite),
    .ex_wreg   (EX_wreg),
    .mem_rw    (MEM_regWrite),
    .mem_wreg  (MEM_wreg),
    .wb_rw     (WB_regWrite),
    .wb_wreg   (WB_wreg),
    .sel_c     (ALUSrcD),
    .ex_hit_c  (rt_ex_hit),
    .mem_hit_c (rt_mem_hit)
  );

  // Hazard detection; a MEM match only matters when EX does not shadow it.
  assign haz_ex  = EX_memRead && (rs_ex_hit || rt_ex_hit);
  assign haz_mem = MEM_memRead && !mem_ready &&
                   ((rs_mem_hit && !rs_ex_hit) || (rt_mem_hit && !rt_ex_hit));
  assign stall   = haz_ex || haz_mem;

  // Front-end controls follow the hazard in the same cycle.
  assign PCWrite     = !stall;
  assign IFID_write  = !stall;
  assign IDEX_bubble = stall;

  // Next state and MEM_WAIT run length.
  always_comb begin
    state_d    = RUN;
    wait_cnt_d = '0;
    unique case (state_q)
      RUN, LOAD_WAIT: begin
        if (haz_ex)       state_d = LOAD_WAIT;
        else if (haz_mem) state_d = MEM_WAIT;
        else              state_d = RUN;
      end
      MEM_WAIT: state_d = haz_mem ? MEM_WAIT : RUN;
      default:  state_d = RUN;
    endcase
    if (state_d == MEM_WAIT) wait_cnt_d = wait_inc(wait_cnt_q);
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (wait_cnt_d >= WAIT_W'(MAX_MEM_WAIT)) timeout_err <= 1'b1;
    end
  end

`ifdef BRANCH_HAZARD_PERF_EN
  // Saturating count of all stall cycles.
  always_ff @(posedge clock) begin
    if (!reset)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif

endmodule
